keypad_paddle_ctrl: RTL and testbench
=====================================

# keypad_paddle_ctrl

Converts the raw scan output of the 4x4 keypad scanner into debounced, auto-repeating paddle movement for both Pong players, and holds the two paddle positions. It sits directly downstream of the keypad scanner: it consumes `keys`/`keypressed` and feeds paddle Y coordinates to the game logic and renderer. The block runs a single-key tracking state machine with debounce, release timeout, hold delay and repeat timers, plus saturating position arithmetic.

## Interface
- `DEBOUNCE_CYC`, 250000: cycles a key must stay held before its first step.
- `RELEASE_CYC`, 16: cycles without a matching `keypressed` after which the key counts as released. Must be ≥ 8, because the scanner only reports a held key once per 4-cycle scan.
- `REPEAT_DELAY`, 5000000: hold time after the first step before auto-repeat starts.
- `REPEAT_PERIOD`, 500000: cycles between repeat steps.
- `POS_W`, 9: paddle position width.
- `MAX_POS`, 400: maximum paddle position (inclusive).
- `STEP`, 4: position change per step.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `keys`  in  4  key code from the scanner.
- `keypressed`  in  1  `keys` is valid this cycle.
- `left_pos`  out  POS_W  left paddle Y.
- `right_pos`  out  POS_W  right paddle Y.
- `step_l`  out  1  one-cycle pulse when the left paddle moves or attempts to move.
- `step_r`  out  1  one-cycle pulse when the right paddle moves or attempts to move.
- `key_valid`  out  1  high in the HELD and REPEAT states.
- `active_key`  out  4  latched key code.

## Operation
- Key map (all other codes are ignored; they neither refresh nor switch the tracker):
  - 1 = left up; 7 = left down.
  - 10 (A) = right up; 12 (C) = right down.
- "Match" means `keypressed` is high and `keys` equals the latched code.
- Timers:
  - The release counter clears on a match, otherwise increments, saturating at `RELEASE_CYC`.
  - Reaching `RELEASE_CYC` means released.
  - Phase timers are 24 bits wide.
- FSM states: IDLE, DEBOUNCE, HELD, REPEAT.
  - IDLE: on a mapped `keypressed`, latch the code, clear the timers, go to DEBOUNCE.
  - DEBOUNCE: when held for `DEBOUNCE_CYC` cycles, emit a step and go to HELD. On release, go to IDLE with no step.
  - HELD: when `REPEAT_DELAY` cycles have elapsed since the first step, emit a step and go to REPEAT. On release, go to IDLE.
  - REPEAT: emit a step every `REPEAT_PERIOD` cycles. On release, go to IDLE.
  - In any non-IDLE state, a different mapped code relatches the new code and restarts in DEBOUNCE. Release has priority over a timer expiry in the same cycle.
- Step arithmetic, computed at POS_W+1 bits:
  - Up: pos − STEP, saturating at 0.
  - Down: pos + STEP, saturating at `MAX_POS`.
  - A step at the limit still pulses `step_l`/`step_r` but leaves the position unchanged.
- Only one paddle moves per step. Both players cannot move simultaneously, by design of the single-key keypad.

## Timing
- Reset values:
  - `left_pos` = `right_pos` = MAX_POS/2 (integer, 200 by default).
  - `step_l` = `step_r` = 0; `key_valid` = 0; `active_key` = 0; state IDLE; all timers 0.
- Reset mid-operation abandons any pending step. No pulse may be emitted in the first cycle after reset deasserts.
- Latency:
  - First step: DEBOUNCE_CYC cycles after the latching `keypressed`.
  - The position update and the step pulse occur on the same clock edge.
  - Repeat steps: REPEAT_DELAY after the first step, then every REPEAT_PERIOD.
- Release is detected exactly RELEASE_CYC cycles after the last match.
- All outputs are registered.

## Configuration
- `KEYPAD_PADDLE_CENTER_EN`:
  - Defined: key 0 is mapped. After a debounced press (DEBOUNCE → HELD), both positions load MAX_POS/2 and both `step_l` and `step_r` pulse once. Holding key 0 does not repeat.
  - Undefined: key 0 is ignored like any other unmapped code.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYC=8, RELEASE_CYC=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, MAX_POS=400, STEP=4.
- Reset → `left_pos`=`right_pos`=200, all pulses 0, `key_valid`=0.
- Key 1 pulsed every 4 cycles for 40 cycles:
  - First `step_l` 8 cycles after the first press, then `left_pos`=196.
  - Repeat at +20, then +5, with `left_pos` decreasing by 4 each time.
- Key 7 held only 5 cycles, then stopped → no step, FSM back to IDLE 8 cycles after the last press.
- `right_pos` driven to 400 via repeated C presses, then one more step → `step_r` pulses, `right_pos` stays 400. Same check for left at 0.
- Key 1 held, switched to key 12 mid-REPEAT → DEBOUNCE restarts; first `step_r` 8 cycles after the switch; no `step_l` after the switch.
- Unmapped key 5 interleaved with key 1 → ignored, key 1 stays tracked. With `KEYPAD_PADDLE_CENTER_EN` defined, key 0 held 8 cycles → both positions 200, one pulse on each step output.

Source files
------------

// File: rtl/keypad_paddle_ctrl_if.sv
// rtl/keypad_paddle_ctrl_if.sv - keypad scan inputs and paddle outputs of keypad_paddle_ctrl
interface keypad_paddle_ctrl_if #(
   parameter int unsigned POS_W = 9
);
   logic [3:0]       keys;
   logic             keypressed;
   logic [POS_W-1:0] left_pos;
   logic [POS_W-1:0] right_pos;
   logic             step_l;
   logic             step_r;
   logic             key_valid;
   logic [3:0]       active_key;

   // scanner/game side
   modport master (
      output keys, keypressed,
      input  left_pos, right_pos, step_l, step_r, key_valid, active_key
   );

   // paddle controller side
   modport slave (
      input  keys, keypressed,
      output left_pos, right_pos, step_l, step_r, key_valid, active_key
   );
endinterface

// File: rtl/keypad_paddle_ctrl.sv
// rtl/keypad_paddle_ctrl.sv - debounced auto-repeat paddle control from keypad scans; KEYPAD_PADDLE_CENTER_EN maps key 0 to recentre
module keypad_paddle_ctrl #(
   parameter int unsigned DEBOUNCE_CYC  = 250000,
   parameter int unsigned RELEASE_CYC   = 16,
   parameter int unsigned REPEAT_DELAY  = 5000000,
   parameter int unsigned REPEAT_PERIOD = 500000,
   parameter int unsigned POS_W         = 9,
   parameter int unsigned MAX_POS       = 400,
   parameter int unsigned STEP          = 4
) (
   input logic                 clk,
   input logic                 rst,
   keypad_paddle_ctrl_if.slave bus
);

`ifdef KEYPAD_PADDLE_CENTER_EN
   localparam bit CENTER_EN = 1'b1;
`else
   localparam bit CENTER_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, REPEAT} state_t;

   localparam int unsigned       REL_W    = $clog2(RELEASE_CYC + 1);
   localparam logic [REL_W-1:0]  REL_LAST = REL_W'(RELEASE_CYC - 1);
   localparam logic [REL_W-1:0]  REL_MAX  = REL_W'(RELEASE_CYC);
   localparam logic [23:0]       DEB_LAST = 24'(DEBOUNCE_CYC - 1);
   localparam logic [23:0]       DLY_LAST = 24'(REPEAT_DELAY - 1);
   localparam logic [23:0]       PER_LAST = 24'(REPEAT_PERIOD - 1);
   localparam logic [POS_W:0]    STEP_W   = (POS_W + 1)'(STEP);
   localparam logic [POS_W:0]    MAX_W    = (POS_W + 1)'(MAX_POS);
   localparam logic [POS_W-1:0]  CENTER   = POS_W'(MAX_POS / 2);

   state_t           state, state_n;
   logic [23:0]      phase_cnt, phase_n;
   logic [REL_W-1:0] rel_cnt, rel_n;
   logic [3:0]       key_q, key_n;
   logic             fire;
   logic             match, press_mapped, released, center_key;

   logic [POS_W-1:0] left_q, right_q;
   logic             step_l_q, step_r_q, key_valid_q;

   function automatic logic is_mapped(input logic [3:0] k);
      return (k == 4'd1) || (k == 4'd7) || (k == 4'd10) || (k == 4'd12) ||
             (CENTER_EN && (k == 4'd0));
   endfunction

   // Widen by one bit so the subtraction cannot wrap before the floor check.
   function automatic logic [POS_W-1:0] pos_up(input logic [POS_W-1:0] p);
      logic [POS_W:0] w;
      w = {1'b0, p};
      if (w < STEP_W) return '0;
      else return POS_W'(w - STEP_W);
   endfunction

   function automatic logic [POS_W-1:0] pos_down(input logic [POS_W-1:0] p);
      logic [POS_W:0] w;
      w = {1'b0, p} + STEP_W;
      if (w > MAX_W) return POS_W'(MAX_W);
      else return POS_W'(w);
   endfunction

   assign match        = bus.keypressed && (bus.keys == key_q);
   assign press_mapped = bus.keypressed && is_mapped(bus.keys);
   assign released     = !match && (rel_cnt >= REL_LAST);
   assign center_key   = CENTER_EN && (key_q == 4'd0);

   // State, latched key and the phase/release timers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         phase_cnt <= '0;
         rel_cnt   <= '0;
         key_q     <= '0;
      end else begin
         state     <= state_n;
         phase_cnt <= phase_n;
         rel_cnt   <= rel_n;
         key_q     <= key_n;
      end
   end

   // Next state: a new mapped key beats release, release beats a timer expiry.
   always_comb begin
      state_n = state;
      key_n   = key_q;
      phase_n = (phase_cnt == 24'hFF_FFFF) ? phase_cnt : phase_cnt + 24'd1;
      rel_n   = (rel_cnt == REL_MAX) ? rel_cnt : rel_cnt + 1'b1;
      fire    = 1'b0;
      if (match) rel_n = '0;
      case (state)
         IDLE: begin
            phase_n = '0;
            rel_n   = '0;
            if (press_mapped) begin
               key_n   = bus.keys;
               state_n = DEBOUNCE;
            end
         end
         default: begin
            if (press_mapped && !match) begin
               key_n   = bus.keys;
               state_n = DEBOUNCE;
               phase_n = '0;
               rel_n   = '0;
            end else if (released) begin
               state_n = IDLE;
               phase_n = '0;
               rel_n   = '0;
            end else begin
               case (state)
                  DEBOUNCE: begin
                     if (phase_cnt == DEB_LAST) begin
                        fire    = 1'b1;
                        state_n = HELD;
                        phase_n = '0;
                     end
                  end
                  HELD: begin
                     // The recentre key fires once and then just sits in HELD.
                     if (!center_key && (phase_cnt == DLY_LAST)) begin
                        fire    = 1'b1;
                        state_n = REPEAT;
                        phase_n = '0;
                     end
                  end
                  REPEAT: begin
                     if (phase_cnt == PER_LAST) begin
                        fire    = 1'b1;
                        phase_n = '0;
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end
      endcase
   end

   // Paddle positions and step pulses, updated on the same edge as a fire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         left_q      <= CENTER;
         right_q     <= CENTER;
         step_l_q    <= 1'b0;
         step_r_q    <= 1'b0;
         key_valid_q <= 1'b0;
      end else begin
         step_l_q    <= 1'b0;
         step_r_q    <= 1'b0;
         key_valid_q <= (state_n == HELD) || (state_n == REPEAT);
         if (fire) begin
            case (key_q)
               4'd1: begin
                  left_q   <= pos_up(left_q);
                  step_l_q <= 1'b1;
               end
               4'd7: begin
                  left_q   <= pos_down(left_q);
                  step_l_q <= 1'b1;
               end
               4'd10: begin
                  right_q  <= pos_up(right_q);
                  step_r_q <= 1'b1;
               end
               4'd12: begin
                  right_q  <= pos_down(right_q);
                  step_r_q <= 1'b1;
               end
               default: begin
                  if (CENTER_EN) begin
                     left_q   <= CENTER;
                     right_q  <= CENTER;
                     step_l_q <= 1'b1;
                     step_r_q <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign bus.left_pos   = left_q;
   assign bus.right_pos  = right_q;
   assign bus.step_l     = step_l_q;
   assign bus.step_r     = step_r_q;
   assign bus.key_valid  = key_valid_q;
   assign bus.active_key = key_q;

endmodule

// File: tb/tb_keypad_paddle_ctrl.sv
// tb/tb_keypad_paddle_ctrl.sv - self-checking bench for keypad_paddle_ctrl
module tb_keypad_paddle_ctrl;

   localparam int DEB = 8;
   localparam int REL = 8;
   localparam int RD  = 20;
   localparam int RP  = 5;
   localparam int MAXP = 400;
   localparam int STP = 4;

`ifdef KEYPAD_PADDLE_CENTER_EN
   localparam bit CENTER_EN = 1'b1;
`else
   localparam bit CENTER_EN = 1'b0;
`endif

   logic clk;
   logic rst;

   keypad_paddle_ctrl_if #(.POS_W(9)) bif ();

   keypad_paddle_ctrl #(
      .DEBOUNCE_CYC  (DEB),
      .RELEASE_CYC   (REL),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP),
      .POS_W         (9),
      .MAX_POS       (MAXP),
      .STEP          (STP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks the session by elapsed time since latch/last match.
   int         n;
   int         m_tl, m_tlast;
   bit         m_active, m_kv, m_sl, m_sr;
   logic [3:0] m_key;
   int         m_left, m_right;

   function automatic bit m_mapped(input logic [3:0] k);
      return (k == 4'd1) || (k == 4'd7) || (k == 4'd10) || (k == 4'd12) ||
             (CENTER_EN && (k == 4'd0));
   endfunction

   task automatic model_reset();
      m_active = 0; m_kv = 0; m_sl = 0; m_sr = 0;
      m_key = 4'd0; m_left = MAXP / 2; m_right = MAXP / 2;
   endtask

   task automatic model_edge(input logic [3:0] k, input logic kp);
      int e;
      bit fire;
      fire = 0; m_sl = 0; m_sr = 0;
      n++;
      if (!m_active) begin
         if (kp && m_mapped(k)) begin
            m_active = 1; m_key = k; m_tl = n; m_tlast = n;
         end
      end else if (kp && m_mapped(k) && (k != m_key)) begin
         m_key = k; m_tl = n; m_tlast = n;
      end else begin
         if (kp && (k == m_key)) m_tlast = n;
         if (n - m_tlast >= REL) begin
            m_active = 0;
         end else begin
            e = n - m_tl;
            if (e == DEB) fire = 1;
            else if (!(CENTER_EN && m_key == 4'd0) && e >= DEB + RD && ((e - DEB - RD) % RP) == 0)
               fire = 1;
         end
      end
      m_kv = m_active && ((n - m_tl) >= DEB);
      if (fire) begin
         case (m_key)
            4'd1:  begin m_left  = (m_left  < STP) ? 0 : m_left - STP;              m_sl = 1; end
            4'd7:  begin m_left  = (m_left  + STP > MAXP) ? MAXP : m_left + STP;    m_sl = 1; end
            4'd10: begin m_right = (m_right < STP) ? 0 : m_right - STP;             m_sr = 1; end
            4'd12: begin m_right = (m_right + STP > MAXP) ? MAXP : m_right + STP;   m_sr = 1; end
            default: begin m_left = MAXP / 2; m_right = MAXP / 2; m_sl = 1; m_sr = 1; end
         endcase
      end
   endtask

   task automatic tick(input logic [3:0] k, input logic kp);
      bif.keys = k;
      bif.keypressed = kp;
      @(posedge clk);
      model_edge(k, kp);
      #1;
      chk($sformatf("model_n%0d", n),
          {bif.active_key, bif.key_valid, bif.step_r, bif.step_l, bif.right_pos, bif.left_pos},
          {m_key, m_kv, m_sr, m_sl, 9'(m_right), 9'(m_left)});
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_left"}, bif.left_pos, 200);
      chk({tag, "_right"}, bif.right_pos, 200);
      chk({tag, "_stepl"}, bif.step_l, 0);
      chk({tag, "_stepr"}, bif.step_r, 0);
      chk({tag, "_kv"}, bif.key_valid, 0);
      chk({tag, "_key"}, bif.active_key, 0);
   endtask

   typedef struct {
      logic [3:0] key;
      bit         press;
      bit         first;
      int         hold;
      int         left;
      int         right;
      bit         sl;
      bit         sr;
      bit         kv;
   } vec_t;

   vec_t vt [15];

   initial begin
      int pc, k, exp, seen_l, seen_r, first_i, len, mode;
      logic [3:0] key;
      logic [3:0] klist [8];
      logic kp;

      // Key 1 tapped every 4 cycles, then released; key 7 single tap vs. debounce tie; key 7 re-press.
      vt[0]  = '{4'd1, 1'b1, 1'b1,  8, 200, 200, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{4'd1, 1'b1, 1'b0,  1, 196, 200, 1'b1, 1'b0, 1'b1};
      vt[2]  = '{4'd1, 1'b1, 1'b0, 19, 196, 200, 1'b0, 1'b0, 1'b1};
      vt[3]  = '{4'd1, 1'b1, 1'b0,  1, 192, 200, 1'b1, 1'b0, 1'b1};
      vt[4]  = '{4'd1, 1'b1, 1'b0,  4, 192, 200, 1'b0, 1'b0, 1'b1};
      vt[5]  = '{4'd1, 1'b1, 1'b0,  1, 188, 200, 1'b1, 1'b0, 1'b1};
      vt[6]  = '{4'd1, 1'b1, 1'b0,  5, 184, 200, 1'b1, 1'b0, 1'b1};
      vt[7]  = '{4'd1, 1'b0, 1'b0,  5, 180, 200, 1'b1, 1'b0, 1'b1};
      vt[8]  = '{4'd1, 1'b0, 1'b0,  1, 180, 200, 1'b0, 1'b0, 1'b0};
      vt[9]  = '{4'd7, 1'b1, 1'b1,  1, 180, 200, 1'b0, 1'b0, 1'b0};
      vt[10] = '{4'd7, 1'b0, 1'b0,  7, 180, 200, 1'b0, 1'b0, 1'b0};
      vt[11] = '{4'd7, 1'b0, 1'b0,  1, 180, 200, 1'b0, 1'b0, 1'b0};
      vt[12] = '{4'd7, 1'b1, 1'b1,  8, 180, 200, 1'b0, 1'b0, 1'b0};
      vt[13] = '{4'd7, 1'b1, 1'b0,  1, 184, 200, 1'b1, 1'b0, 1'b1};
      vt[14] = '{4'd7, 1'b0, 1'b0,  8, 184, 200, 1'b0, 1'b0, 1'b0};

      klist[0] = 4'd0;  klist[1] = 4'd1; klist[2] = 4'd5;  klist[3] = 4'd7;
      klist[4] = 4'd10; klist[5] = 4'd12; klist[6] = 4'd3; klist[7] = 4'd15;

      n = 0;
      rst = 1'b1;
      bif.keys = 4'd0;
      bif.keypressed = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("reset");
      rst = 1'b0;

      pc = 0;
      for (int r = 0; r < 15; r++) begin
         if (vt[r].first) pc = 0;
         for (int i = 0; i < vt[r].hold; i++) begin
            tick(vt[r].key, vt[r].press && (pc % 4 == 0));
            pc++;
         end
         chk($sformatf("row%0d_left", r),  bif.left_pos,  vt[r].left);
         chk($sformatf("row%0d_right", r), bif.right_pos, vt[r].right);
         chk($sformatf("row%0d_stepl", r), bif.step_l,    vt[r].sl);
         chk($sformatf("row%0d_stepr", r), bif.step_r,    vt[r].sr);
         chk($sformatf("row%0d_kv", r),    bif.key_valid, vt[r].kv);
      end

      // Right paddle driven into the bottom limit, plus one more step.
      k = 0; exp = 200; seen_l = 0;
      for (int i = 0; i < 400 && k < 51; i++) begin
         tick(4'd12, 1'b1);
         if (bif.step_l) seen_l++;
         if (bif.step_r) begin
            k++;
            exp = (exp + 4 > 400) ? 400 : exp + 4;
            chk($sformatf("satr_pos%0d", k), bif.right_pos, exp);
         end
      end
      chk("satr_steps", k, 51);
      chk("satr_final", bif.right_pos, 400);
      chk("satr_no_stepl", seen_l, 0);
      repeat (10) tick(4'd0, 1'b0);

      // Left paddle driven into the top limit (from 184), plus one more step.
      k = 0; exp = 184; seen_r = 0;
      for (int i = 0; i < 400 && k < 47; i++) begin
         tick(4'd1, 1'b1);
         if (bif.step_r) seen_r++;
         if (bif.step_l) begin
            k++;
            exp = (exp < 4) ? 0 : exp - 4;
            chk($sformatf("satl_pos%0d", k), bif.left_pos, exp);
         end
      end
      chk("satl_steps", k, 47);
      chk("satl_final", bif.left_pos, 0);
      chk("satl_no_stepr", seen_r, 0);
      repeat (10) tick(4'd0, 1'b0);

      // Key 1 into REPEAT, then switch to key 12.
      repeat (40) tick(4'd1, 1'b1);
      chk("sw_kv_before", bif.key_valid, 1);
      first_i = -1; seen_l = 0;
      for (int i = 0; i < 16; i++) begin
         tick(4'd12, 1'b1);
         if (bif.step_r && first_i < 0) first_i = i;
         if (bif.step_l) seen_l++;
      end
      chk("sw_first_stepr", first_i, 8);
      chk("sw_no_stepl", seen_l, 0);
      chk("sw_key", bif.active_key, 12);
      repeat (10) tick(4'd0, 1'b0);
      chk("sw_released_kv", bif.key_valid, 0);

      // Unmapped key 5 alone, then interleaved with key 1.
      repeat (4) tick(4'd5, 1'b1);
      chk("unmapped_idle_key", bif.active_key, 12);
      chk("unmapped_idle_kv", bif.key_valid, 0);
      first_i = -1;
      for (int i = 0; i < 12; i++) begin
         key = (i % 4 == 0) ? 4'd1 : 4'd5;
         kp  = (i % 4 == 0) || (i % 4 == 2);
         tick(key, kp);
         if (bif.step_l && first_i < 0) first_i = i;
      end
      chk("mix_first_stepl", first_i, 8);
      chk("mix_key", bif.active_key, 1);
      chk("mix_kv", bif.key_valid, 1);
      repeat (10) tick(4'd0, 1'b0);

      // Key 0 held: recentre when enabled, ignored otherwise.
      seen_l = 0; seen_r = 0; first_i = -1;
      for (int i = 0; i < 40; i++) begin
         tick(4'd0, 1'b1);
         if (bif.step_l) seen_l++;
         if (bif.step_r) seen_r++;
         if (bif.step_l && first_i < 0) first_i = i;
      end
`ifdef KEYPAD_PADDLE_CENTER_EN
      chk("ctr_stepl_cnt", seen_l, 1);
      chk("ctr_stepr_cnt", seen_r, 1);
      chk("ctr_first", first_i, 8);
      chk("ctr_left", bif.left_pos, 200);
      chk("ctr_right", bif.right_pos, 200);
      chk("ctr_kv", bif.key_valid, 1);
`else
      chk("key0_stepl_cnt", seen_l, 0);
      chk("key0_stepr_cnt", seen_r, 0);
      chk("key0_left", bif.left_pos, 0);
      chk("key0_right", bif.right_pos, 400);
      chk("key0_kv", bif.key_valid, 0);
`endif
      repeat (10) tick(4'd0, 1'b0);

      // Reset while a debounce is pending abandons the step.
      repeat (6) tick(4'd10, 1'b1);
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      chk_reset_state("midrst");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      seen_r = 0;
      for (int i = 0; i < 12; i++) begin
         tick(4'd10, 1'b0);
         if (i == 0) chk("midrst_first_cycle_stepr", bif.step_r, 0);
         if (bif.step_r) seen_r++;
      end
      chk("midrst_no_stepr", seen_r, 0);
      chk("midrst_right", bif.right_pos, 200);

      // Randomised segments against the reference model.
      repeat (150) begin
         key  = klist[$urandom_range(0, 7)];
         mode = $urandom_range(0, 3);
         len  = $urandom_range(1, 40);
         for (int i = 0; i < len; i++) begin
            case (mode)
               0: kp = 1'b1;
               1: kp = (i % 4 == 0);
               2: kp = ($urandom_range(0, 3) == 0);
               default: kp = 1'b0;
            endcase
            tick(key, kp);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
